// File: rtl/select_action_seq.sv
// Sequential switch/LED operation selector: ADD, SUB, shift-add MULT and LZC on two operand halves.
// Optional macro SELECT_ACTION_AUTO_START_EN launches an operation whenever {selector, sw} changes.
module select_action_seq #(
    parameter  int WIDTH = 16,
    localparam int HALF  = WIDTH / 2,
    localparam int CNT_W = $clog2(HALF + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       selector,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int LZC_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_LZC  = 3'd3;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Handshake: start is sampled only in IDLE; busy is high for every CALC
    // cycle; done pulses for one cycle as led/err take their new values.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [HALF-1:0]    b_q, b_d;
    logic [2:0]         sel_q, sel_d;
    logic [WIDTH-1:0]   sw_q, sw_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   led_q, led_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               launch;

    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH-1:0]   acc_step;
    logic [LZC_W-1:0]   lzc;
    logic               lzc_found;
    logic               sel_valid;

`ifdef SELECT_ACTION_AUTO_START_EN
    logic [WIDTH+2:0]   last_q, last_d;

    // Any difference from the last completed request re-runs the operation.
    assign launch = start | ({selector, sw} != last_q);
`else
    assign launch = start;
`endif

    // Single-cycle results all derive from the latched switch word.
    assign op_a      = {{(WIDTH-HALF){1'b0}}, sw_q[WIDTH-1:HALF]};
    assign op_b      = {{(WIDTH-HALF){1'b0}}, sw_q[HALF-1:0]};
    assign sel_valid = (sel_q <= OP_LZC);
    assign acc_step  = acc_q + (b_q[0] ? a_q : {WIDTH{1'b0}});

    always_comb begin
        lzc       = LZC_W'(WIDTH);
        lzc_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!lzc_found && sw_q[i]) begin
                lzc       = LZC_W'(WIDTH - 1 - i);
                lzc_found = 1'b1;
            end
        end
    end

    always_comb begin
        single_res = {WIDTH{1'b0}};
        case (sel_q)
            OP_ADD:  single_res = op_a + op_b;
            OP_SUB:  single_res = op_a - op_b;
            OP_LZC:  single_res = {{(WIDTH-LZC_W){1'b0}}, lzc};
            default: single_res = {WIDTH{1'b0}};
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        sw_d    = sw_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef SELECT_ACTION_AUTO_START_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (launch) begin
                    a_d     = {{(WIDTH-HALF){1'b0}}, sw[WIDTH-1:HALF]};
                    b_d     = sw[HALF-1:0];
                    sel_d   = selector;
                    sw_d    = sw;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = CALC;
                end
            end
            CALC: begin
                if (sel_q == OP_MULT) begin
                    acc_d = acc_step;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    // The last step's partial product goes straight to led.
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        led_d   = acc_step;
                        err_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef SELECT_ACTION_AUTO_START_EN
                        last_d  = {sel_q, sw_q};
`endif
                    end
                end else begin
                    led_d   = single_res;
                    err_d   = !sel_valid;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef SELECT_ACTION_AUTO_START_EN
                    last_d  = {sel_q, sw_q};
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            sw_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            sw_q    <= sw_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef SELECT_ACTION_AUTO_START_EN
    // All-ones never matches a plausible first request, so one op runs after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign led  = led_q;
    assign busy = (state_q == CALC);
    assign done = done_q;
    assign err  = err_q;

endmodule
